calc_seq: RTL and testbench
===========================

# calc_seq

Job sequencer for the bit-plane calculation datapath. It accepts one matrix-tile job at a time, walks the tile and bit-plane loops, and drives the A and S read addresses and the `start` pulse to the calc unit. It times each step to the unit's fixed latency and drives `init`, `acc_en` and `shift_amt` to the eight engine adders. It finishes every job with a single result write-back handshake at the B address.

## Interface
- `ADDR_W`, 32, width of all address ports
- `KT_W`, 16, width of the tile-count field
- `SHIFT_W`, 3, width of the plane index / shift amount
- `CALC_LAT`, 4, cycles from `start` to valid engine result (≥1)
- `A_STRIDE`, 256, byte step of `addr_A` per tile (one 8×4×64-bit data block)
- `S_STRIDE`, 20, byte step of `addr_S` per step (one 160-bit weight word)
- `clk` in 1: the single clock
- `rst_n` in 1: asynchronous, active-low reset
- `cmd_valid` in 1: job request
- `cmd_ready` out 1: high only in IDLE
- `cmd_base_a`, `cmd_base_s`, `cmd_base_b` in ADDR_W: base addresses
- `cmd_ktiles` in KT_W: number of tiles (0 legal)
- `cmd_planes_m1` in SHIFT_W: number of bit-planes minus one (1..8 planes)
- `start` out 1: one-cycle pulse to calc unit
- `addr_A`, `addr_S`, `addr_B` out ADDR_W: read/write addresses
- `init` out 1: clear accumulator on this accumulate
- `acc_en` out 1: adder accumulate strobe
- `shift_amt` out SHIFT_W: shift applied by adders, equals current plane index
- `wb_valid` out 1, `wb_ready` in 1: result write-back handshake
- `busy` out 1: state ≠ IDLE
- `done` out 1: one-cycle job-complete pulse
- `perf_cycles` out 32: busy-cycle count of last job

## Operation
- States: IDLE, ISSUE, WAIT, ACC, WB, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch all cmd fields and clear counters `k`=0, `p`=0, `first`=1.
  - If `cmd_ktiles`==0, go to DONE: no `start`, no `wb_valid`.
  - Otherwise go to ISSUE.
- ISSUE: `start`=1 for one cycle. `addr_A`=base_a+k·A_STRIDE. `addr_S`=base_s+(k·(planes)+p)·S_STRIDE. Go to WAIT with wait counter = CALC_LAT−1.
- WAIT: addresses held. Counter decrements; at 0, go to ACC.
- ACC: `acc_en`=1, `shift_amt`=p, `init`=`first`. Then clear `first`.
  - If p<planes−1: p++.
  - Else p=0, k++.
  - If the last step (k==ktiles−1, p==planes−1) was just done, go to WB. Otherwise go to ISSUE.
- Loop order: plane inner, tile outer.
- WB: `wb_valid`=1, `addr_B`=base_b, held stable until `wb_ready` is sampled high, then DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent.
- Outputs outside their owning state hold 0, except `addr_A`, `addr_S` and `addr_B`, which hold their last value.
- `cmd_valid` while busy is ignored; it is not queued.

## Timing
- Reset values: every output is 0, including `cmd_ready`, which reads 0 only during reset and rises in the first cycle after release.
- Handshake in cycle 0 → `start` in cycle 1 → `acc_en` in cycle 1+CALC_LAT+1. Each step takes CALC_LAT+2 cycles.
- For N = ktiles·planes steps, `wb_valid` rises in cycle N·(CALC_LAT+2)+1.
- `done` occurs 1 cycle after the `wb_valid`·`wb_ready` cycle. `cmd_ready` is high the cycle after `done`.
- Zero-tile job: `done` in cycle 1, `cmd_ready` in cycle 2.
- Asserting `rst_n` mid-job aborts immediately. All state returns to IDLE values and no `done` is produced.

## Configuration
- `CALC_SEQ_PERF_EN` defined: a 32-bit counter clears on job accept and increments on every cycle with `busy`=1, saturating at all-ones. It is copied to `perf_cycles` when DONE is entered.
- Not defined: counter logic is absent and `perf_cycles` is tied to 0.

## Structure
- Shared package `calc_pkg`: the state enum `calc_seq_state_t`, default stride and latency constants, and a `calc_cmd_t` struct bundling the cmd fields.
- One sub-module, `calc_seq_addr`: the address generator. It holds the k/p counters and the running A/S addresses, is incremented by adders rather than multipliers, and is controlled by load/step strobes from the FSM.

## Test plan
All scenarios use CALC_LAT=4.
- Reset: `rst_n`=0 → all outputs 0. After release → `cmd_ready`=1 next cycle.
- ktiles=2, planes_m1=1, base_a=0x1000, base_s=0x2000, base_b=0x3000 →
  - four `start` pulses, 6 cycles apart
  - `addr_A` = 0x1000, 0x1000, 0x1100, 0x1100
  - `addr_S` = 0x2000, 0x2014, 0x2028, 0x203C
  - `shift_amt` = 0, 1, 0, 1
  - `init` only on the first `acc_en`
  - `wb_valid` in cycle 25 with `addr_B`=0x3000
- Same job with `wb_ready` held low for 5 cycles → `wb_valid` and `addr_B` stay stable, and `done` comes exactly 1 cycle after `wb_ready`.
- ktiles=0 → `done` in cycle 1, no `start`, no `wb_valid`.
- base_a=0xFFFF_FF80, ktiles=2, planes_m1=0 → second `addr_A`=0x0000_0080 (wraps).
- `rst_n` pulsed in WAIT of step 2 → immediately IDLE values, no `done`. A new job then runs correctly with `init` on its first accumulate. With `CALC_SEQ_PERF_EN`, a planes_m1=0, ktiles=1 job gives `perf_cycles`=7.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and default constants for the bit-plane calc job sequencer.
// No logic: state encoding, cmd bundle and parameter defaults only.
// Consumers import calc_pkg::*; field widths here set the internal datapath width.
package calc_pkg;

    localparam int CALC_ADDR_W   = 32;
    localparam int CALC_KT_W     = 16;
    localparam int CALC_SHIFT_W  = 3;
    localparam int CALC_LAT_DEF  = 4;
    localparam int CALC_A_STRIDE = 256;
    localparam int CALC_S_STRIDE = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACC,
        ST_WB,
        ST_DONE
    } calc_seq_state_t;

    typedef struct packed {
        logic [CALC_ADDR_W-1:0]  base_a;
        logic [CALC_ADDR_W-1:0]  base_s;
        logic [CALC_ADDR_W-1:0]  base_b;
        logic [CALC_KT_W-1:0]    ktiles;
        logic [CALC_SHIFT_W-1:0] planes_m1;
    } calc_cmd_t;

endpackage

// File: rtl/calc_seq_addr.sv
// Address generator: tile/plane counters with running A, S and B addresses.
// Latency: addresses update the cycle after a load/step/wb_load strobe.
// No backpressure: strobes come from the sequencer FSM, one per step.
module calc_seq_addr
    import calc_pkg::*;
#(
    parameter int A_STRIDE = CALC_A_STRIDE,
    parameter int S_STRIDE = CALC_S_STRIDE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  calc_cmd_t               cmd,
    input  logic                    step,
    input  logic                    wb_load,
    output logic                    last,
    output logic [CALC_SHIFT_W-1:0] plane,
    output logic [CALC_ADDR_W-1:0]  addr_a,
    output logic [CALC_ADDR_W-1:0]  addr_s,
    output logic [CALC_ADDR_W-1:0]  addr_b
);

    localparam logic [CALC_ADDR_W-1:0] A_INC = CALC_ADDR_W'(A_STRIDE);
    localparam logic [CALC_ADDR_W-1:0] S_INC = CALC_ADDR_W'(S_STRIDE);

    logic [CALC_KT_W-1:0]    k_q;
    logic [CALC_KT_W-1:0]    kt_m1_q;
    logic [CALC_SHIFT_W-1:0] p_q;
    logic [CALC_SHIFT_W-1:0] pm1_q;
    logic [CALC_ADDR_W-1:0]  a_q;
    logic [CALC_ADDR_W-1:0]  s_q;
    logic [CALC_ADDR_W-1:0]  b_base_q;
    logic [CALC_ADDR_W-1:0]  b_q;

    // S advances every step (plane inner loop); A only when the plane index wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q      <= '0;
            kt_m1_q  <= '0;
            p_q      <= '0;
            pm1_q    <= '0;
            a_q      <= '0;
            s_q      <= '0;
            b_base_q <= '0;
            b_q      <= '0;
        end else begin
            if (load) begin
                k_q      <= '0;
                p_q      <= '0;
                kt_m1_q  <= cmd.ktiles - CALC_KT_W'(1);
                pm1_q    <= cmd.planes_m1;
                a_q      <= cmd.base_a;
                s_q      <= cmd.base_s;
                b_base_q <= cmd.base_b;
            end else if (step) begin
                s_q <= s_q + S_INC;
                if (p_q == pm1_q) begin
                    p_q <= '0;
                    k_q <= k_q + CALC_KT_W'(1);
                    a_q <= a_q + A_INC;
                end else begin
                    p_q <= p_q + CALC_SHIFT_W'(1);
                end
            end
            if (wb_load) begin
                b_q <= b_base_q;
            end
        end
    end

    assign last   = (k_q == kt_m1_q) && (p_q == pm1_q);
    assign plane  = p_q;
    assign addr_a = a_q;
    assign addr_s = s_q;
    assign addr_b = b_q;

endmodule

// File: rtl/calc_seq.sv
// Job sequencer for the bit-plane calc unit; optional busy-cycle counter under CALC_SEQ_PERF_EN.
// Latency: start 1 cycle after accept, each step CALC_LAT+2 cycles, done 1 cycle after write-back.
// Backpressure: cmd_ready only in IDLE (no queueing); WB holds wb_valid/addr_B until wb_ready.
module calc_seq
    import calc_pkg::*;
#(
    parameter int ADDR_W   = CALC_ADDR_W,
    parameter int KT_W     = CALC_KT_W,
    parameter int SHIFT_W  = CALC_SHIFT_W,
    parameter int CALC_LAT = CALC_LAT_DEF,
    parameter int A_STRIDE = CALC_A_STRIDE,
    parameter int S_STRIDE = CALC_S_STRIDE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ADDR_W-1:0]  cmd_base_a,
    input  logic [ADDR_W-1:0]  cmd_base_s,
    input  logic [ADDR_W-1:0]  cmd_base_b,
    input  logic [KT_W-1:0]    cmd_ktiles,
    input  logic [SHIFT_W-1:0] cmd_planes_m1,
    output logic               start,
    output logic [ADDR_W-1:0]  addr_A,
    output logic [ADDR_W-1:0]  addr_S,
    output logic [ADDR_W-1:0]  addr_B,
    output logic               init,
    output logic               acc_en,
    output logic [SHIFT_W-1:0] shift_amt,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic               busy,
    output logic               done,
    output logic [31:0]        perf_cycles
);

    localparam int WAIT_W = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;

    calc_seq_state_t state_q, state_d;
    logic              rdy_q;
    logic              first_q;
    logic [WAIT_W-1:0] wait_q;
    calc_cmd_t         cmd_in;
    logic              accept;
    logic              addr_load;
    logic              addr_step;
    logic              b_load;
    logic              last;
    logic [CALC_SHIFT_W-1:0] plane;
    logic [CALC_ADDR_W-1:0]  addr_a_w;
    logic [CALC_ADDR_W-1:0]  addr_s_w;
    logic [CALC_ADDR_W-1:0]  addr_b_w;

    always_comb begin
        cmd_in           = '0;
        cmd_in.base_a    = CALC_ADDR_W'(cmd_base_a);
        cmd_in.base_s    = CALC_ADDR_W'(cmd_base_s);
        cmd_in.base_b    = CALC_ADDR_W'(cmd_base_b);
        cmd_in.ktiles    = CALC_KT_W'(cmd_ktiles);
        cmd_in.planes_m1 = CALC_SHIFT_W'(cmd_planes_m1);
    end

    // rdy_q keeps cmd_ready low while reset is held, even though the state is IDLE.
    assign cmd_ready = rdy_q && (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        acc_en    = 1'b0;
        init      = 1'b0;
        shift_amt = '0;
        wb_valid  = 1'b0;
        done      = 1'b0;
        addr_load = 1'b0;
        addr_step = 1'b0;
        b_load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_ktiles == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_ISSUE;
                        addr_load = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                start   = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_ACC;
                end
            end
            ST_ACC: begin
                acc_en    = 1'b1;
                init      = first_q;
                shift_amt = SHIFT_W'(plane);
                // Final step leaves A/S untouched so they hold the last issued addresses.
                if (last) begin
                    state_d = ST_WB;
                    b_load  = 1'b1;
                end else begin
                    state_d   = ST_ISSUE;
                    addr_step = 1'b1;
                end
            end
            ST_WB: begin
                wb_valid = 1'b1;
                if (wb_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
            first_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            if (accept) begin
                first_q <= 1'b1;
            end else if (state_q == ST_ACC) begin
                first_q <= 1'b0;
            end
            if (state_q == ST_ISSUE) begin
                wait_q <= WAIT_W'(CALC_LAT - 1);
            end else if (state_q == ST_WAIT && wait_q != '0) begin
                wait_q <= wait_q - WAIT_W'(1);
            end
        end
    end

    calc_seq_addr #(
        .A_STRIDE (A_STRIDE),
        .S_STRIDE (S_STRIDE)
    ) u_addr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (addr_load),
        .cmd     (cmd_in),
        .step    (addr_step),
        .wb_load (b_load),
        .last    (last),
        .plane   (plane),
        .addr_a  (addr_a_w),
        .addr_s  (addr_s_w),
        .addr_b  (addr_b_w)
    );

    assign addr_A = ADDR_W'(addr_a_w);
    assign addr_S = ADDR_W'(addr_s_w);
    assign addr_B = ADDR_W'(addr_b_w);

`ifdef CALC_SEQ_PERF_EN
    logic [31:0] cyc_q;
    logic [31:0] cyc_inc;
    logic [31:0] perf_q;

    assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;

    // Snapshot includes the busy cycle that is transitioning into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q  <= '0;
            perf_q <= '0;
        end else begin
            if (accept) begin
                cyc_q <= '0;
            end else if (busy) begin
                cyc_q <= cyc_inc;
            end
            if (state_d == ST_DONE && state_q != ST_DONE) begin
                perf_q <= (state_q == ST_IDLE) ? '0 : cyc_inc;
            end
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_calc_seq.sv
// Directed bench for calc_seq: a step/timeline model of each job checked every cycle,
// plus literal expectations for the documented address, timing and perf values.
module tb_calc_seq;

    localparam int LAT   = 4;
    localparam int L     = LAT + 2;
    localparam int A_STR = 256;
    localparam int S_STR = 20;
`ifdef CALC_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam logic [31:0] PERF_LIT = PERF ? 32'd7 : 32'd0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_base_a = '0;
    logic [31:0] cmd_base_s = '0;
    logic [31:0] cmd_base_b = '0;
    logic [15:0] cmd_ktiles = '0;
    logic [2:0]  cmd_planes_m1 = '0;
    logic        start;
    logic [31:0] addr_A, addr_S, addr_B;
    logic        init, acc_en;
    logic [2:0]  shift_amt;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic        busy, done;
    logic [31:0] perf_cycles;

    always #5 clk = ~clk;

    calc_seq #(.CALC_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base_a(cmd_base_a), .cmd_base_s(cmd_base_s), .cmd_base_b(cmd_base_b),
        .cmd_ktiles(cmd_ktiles), .cmd_planes_m1(cmd_planes_m1),
        .start(start), .addr_A(addr_A), .addr_S(addr_S), .addr_B(addr_B),
        .init(init), .acc_en(acc_en), .shift_amt(shift_amt),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .busy(busy), .done(done), .perf_cycles(perf_cycles)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Job description and state the model needs
    bit          chk_on = 1'b0;
    bit          job_on = 1'b0;
    int          t = 0;
    logic [31:0] j_ba, j_bs, j_bb;
    int          j_kt = 0, j_pl = 1, j_wd = 0;
    logic [31:0] hold_a = '0, hold_s = '0, hold_b = '0, hold_perf = '0;

    logic [31:0] cap_a[$];
    logic [31:0] cap_s[$];
    logic [31:0] cap_sh[$];
    logic [31:0] cap_init[$];
    int          wb_t = -1, hs_t = -1, done_t = -1;

    // Expected outputs derived from the step timeline: step i spans cycles 1+i*L .. (i+1)*L.
    always @(negedge clk) begin
        logic        e_rdy, e_start, e_acc, e_init, e_wb, e_busy, e_done;
        logic [31:0] e_sh, e_a, e_s, e_b, e_perf;
        int          n, i, ph, e_end;
        if (chk_on) begin
            e_rdy = 1'b1; e_start = 1'b0; e_acc = 1'b0; e_init = 1'b0;
            e_wb = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_sh = '0;
            e_a = hold_a; e_s = hold_s; e_b = hold_b; e_perf = hold_perf;
            if (job_on && t > 0) begin
                if (j_kt == 0) begin
                    e_perf = '0;
                    if (t == 1) begin
                        e_rdy = 1'b0; e_busy = 1'b1; e_done = 1'b1;
                    end
                end else begin
                    n     = j_kt * j_pl;
                    e_end = n * L;
                    if (t <= e_end) begin
                        i  = (t - 1) / L;
                        ph = (t - 1) % L;
                        e_rdy = 1'b0; e_busy = 1'b1;
                        e_start = (ph == 0);
                        e_acc   = (ph == L - 1);
                        e_init  = e_acc && (i == 0);
                        e_sh    = e_acc ? 32'(i % j_pl) : 32'd0;
                        e_a     = j_ba + 32'((i / j_pl) * A_STR);
                        e_s     = j_bs + 32'(i * S_STR);
                    end else begin
                        e_a = j_ba + 32'(((n - 1) / j_pl) * A_STR);
                        e_s = j_bs + 32'((n - 1) * S_STR);
                        e_b = j_bb;
                        if (t <= e_end + 2 + j_wd) begin
                            e_rdy = 1'b0; e_busy = 1'b1;
                            if (t == e_end + 2 + j_wd) e_done = 1'b1;
                            else                       e_wb   = 1'b1;
                        end
                        if (t >= e_end + 2 + j_wd)
                            e_perf = PERF ? 32'(e_end + 1 + j_wd) : 32'd0;
                    end
                end
            end
            chk("cmd_ready", 32'(cmd_ready), 32'(e_rdy));
            chk("start", 32'(start), 32'(e_start));
            chk("acc_en", 32'(acc_en), 32'(e_acc));
            chk("init", 32'(init), 32'(e_init));
            chk("shift_amt", 32'(shift_amt), e_sh);
            chk("wb_valid", 32'(wb_valid), 32'(e_wb));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("addr_A", addr_A, e_a);
            chk("addr_S", addr_S, e_s);
            chk("addr_B", addr_B, e_b);
            chk("perf_cycles", perf_cycles, e_perf);
            if (job_on) begin
                if (start) begin
                    cap_a.push_back(addr_A);
                    cap_s.push_back(addr_S);
                end
                if (acc_en) begin
                    cap_sh.push_back(32'(shift_amt));
                    cap_init.push_back(32'(init));
                end
                if (wb_valid && wb_t < 0) wb_t = t;
                if (wb_valid && wb_ready && hs_t < 0) hs_t = t;
                if (done && done_t < 0) done_t = t;
                t++;
            end
        end
    end

    task automatic begin_job(input logic [31:0] ba, bs, bb, input int kt, pm1, wd);
        @(posedge clk); #1;
        j_ba = ba; j_bs = bs; j_bb = bb; j_kt = kt; j_pl = pm1 + 1; j_wd = wd;
        cap_a.delete(); cap_s.delete(); cap_sh.delete(); cap_init.delete();
        wb_t = -1; hs_t = -1; done_t = -1;
        cmd_base_a = ba; cmd_base_s = bs; cmd_base_b = bb;
        cmd_ktiles = 16'(kt); cmd_planes_m1 = 3'(pm1);
        cmd_valid = 1'b1; wb_ready = 1'b0;
        t = 0; job_on = 1'b1;
    endtask

    task automatic drive_cycle(input int c);
        int e_end;
        e_end = j_kt * j_pl * L;
        @(posedge clk); #1;
        cmd_valid = (j_kt != 0) && (c < 3);   // extra requests while busy must be ignored
        wb_ready  = (j_kt != 0) && (c >= e_end + 1 + j_wd);
    endtask

    task automatic run_job(input logic [31:0] ba, bs, bb, input int kt, pm1, wd);
        int n, total;
        begin_job(ba, bs, bb, kt, pm1, wd);
        n = kt * (pm1 + 1);
        total = (kt == 0) ? 2 : n * L + wd + 3;
        for (int c = 1; c <= total; c++) drive_cycle(c);
        @(posedge clk); #1;
        if (kt != 0) begin
            hold_a    = ba + 32'(((n - 1) / (pm1 + 1)) * A_STR);
            hold_s    = bs + 32'((n - 1) * S_STR);
            hold_b    = bb;
            hold_perf = PERF ? 32'(n * L + 1 + wd) : 32'd0;
        end else begin
            hold_perf = '0;
        end
        job_on = 1'b0; cmd_valid = 1'b0; wb_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_start"}, 32'(start), 32'd0);
        chk({tag, "_acc_en"}, 32'(acc_en), 32'd0);
        chk({tag, "_init"}, 32'(init), 32'd0);
        chk({tag, "_shift"}, 32'(shift_amt), 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_addr_A"}, addr_A, 32'd0);
        chk({tag, "_addr_S"}, addr_S, 32'd0);
        chk({tag, "_addr_B"}, addr_B, 32'd0);
        chk({tag, "_perf"}, perf_cycles, 32'd0);
    endtask

    logic [31:0] lit_a[4]  = '{32'h1000, 32'h1000, 32'h1100, 32'h1100};
    logic [31:0] lit_s[4]  = '{32'h2000, 32'h2014, 32'h2028, 32'h203C};
    logic [31:0] lit_sh[4] = '{32'd0, 32'd1, 32'd0, 32'd1};
    logic [31:0] lit_in[4] = '{32'd1, 32'd0, 32'd0, 32'd0};

    initial begin
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_on = 1'b1;

        // Two tiles, two planes
        run_job(32'h1000, 32'h2000, 32'h3000, 2, 1, 0);
        chk("lit_start_count", 32'(cap_a.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("lit_addr_A%0d", k), cap_a[k], lit_a[k]);
            chk($sformatf("lit_addr_S%0d", k), cap_s[k], lit_s[k]);
            chk($sformatf("lit_shift%0d", k), cap_sh[k], lit_sh[k]);
            chk($sformatf("lit_init%0d", k), cap_init[k], lit_in[k]);
        end
        chk("lit_wb_cycle", 32'(wb_t), 32'd25);
        chk("lit_done_cycle", 32'(done_t), 32'd26);

        // Same job with write-back stalled for 5 cycles
        run_job(32'h1000, 32'h2000, 32'h3000, 2, 1, 5);
        chk("lit_stall_wb_cycle", 32'(wb_t), 32'd25);
        chk("lit_stall_hs_cycle", 32'(hs_t), 32'd30);
        chk("lit_stall_done_cycle", 32'(done_t), 32'd31);

        // Zero-tile job
        run_job(32'h5000, 32'h6000, 32'h7000, 0, 2, 0);
        chk("lit_zero_done_cycle", 32'(done_t), 32'd1);
        chk("lit_zero_starts", 32'(cap_a.size()), 32'd0);
        chk("lit_zero_wb", 32'(wb_t), 32'hFFFF_FFFF);

        // A address wraps modulo 2^32
        run_job(32'hFFFF_FF80, 32'h0000_0100, 32'h0000_0200, 2, 0, 0);
        chk("lit_wrap_addr_A0", cap_a[0], 32'hFFFF_FF80);
        chk("lit_wrap_addr_A1", cap_a[1], 32'h0000_0080);

        // Reset during WAIT of step 2 aborts the job
        begin_job(32'h1000, 32'h2000, 32'h3000, 2, 1, 0);
        for (int c = 1; c <= 8; c++) drive_cycle(c);
        @(posedge clk); #1;
        rst_n = 1'b0; chk_on = 1'b0; job_on = 1'b0;
        cmd_valid = 1'b0; wb_ready = 1'b0;
        #1;
        check_all_zero("abort");
        hold_a = '0; hold_s = '0; hold_b = '0; hold_perf = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_on = 1'b1;

        run_job(32'h4000, 32'h8000, 32'hC000, 1, 0, 0);
        chk("lit_post_reset_init", cap_init[0], 32'd1);
        chk("lit_post_reset_done", 32'(done_t), 32'd8);
        chk("lit_perf", perf_cycles, PERF_LIT);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
